// File: rtl/rx_sample_buffer.sv
// Receive-side sample sink: captures AXI-stream beats into a FIFO with no back-pressure,
// drops and counts beats that arrive while full, and serves them through a registered pop port.
module rx_sample_buffer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  axis_tvalid_i,
  input  logic [DATA_WIDTH-1:0] axis_tdata_i,
  input  logic                  capture_en_i,
  input  logic                  clear_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [15:0]           dropped_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;

  logic push_req;
  logic push;
  logic pop;
  logic drop;

  // A full FIFO still accepts a beat when a pop frees a slot on the same edge.
  assign push_req = axis_tvalid_i & capture_en_i & ~clear_i;
  assign pop      = rd_en_i & ~empty_o & ~clear_i;
  assign push     = push_req & (~full_o | pop);
  assign drop     = push_req & full_o & ~pop;

  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_COUNT);

  // NOTE: storage is deliberately left out of reset so it maps onto block RAM;
  // only pointers, counters and output registers carry reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= axis_tdata_i;
    end
  end

  // NOTE: non-blocking assignments here make the read of mem[rd_ptr] see the
  // pre-edge contents, so a same-edge push into the slot being popped (full case)
  // returns the oldest entry rather than the new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      dropped_o  <= '0;
    end else if (clear_i) begin
      // rd_data_o intentionally holds its last value across a flush.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_valid_o <= 1'b0;
      overflow_o <= 1'b0;
      dropped_o  <= '0;
    end else begin
      rd_valid_o <= pop;
      if (pop) begin
        rd_data_o <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
        if (dropped_o != 16'hFFFF) begin
          dropped_o <= dropped_o + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/rx_sample_buffer.md
# rx_sample_buffer

Receive-side sink for the RX chain's AXI-stream sample output. Captures each `axis_tvalid_i` beat into an on-chip FIFO, gated by a capture enable, and presents the samples to the bus/register side through a pop interface. The upstream chain has no `tready`, so the block never back-pressures. Samples that arrive while the FIFO is full are dropped and counted.

## Interface
- `ADDR_WIDTH`, default 8: FIFO address width. Depth is 2^ADDR_WIDTH entries (256).
- `DATA_WIDTH`, default 32: sample width. Matches the RX chain `tdata`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `axis_tvalid_i`  in  1  sample strobe from the RX chain; single-cycle or back-to-back.
- `axis_tdata_i`  in  DATA_WIDTH  sample data; qualified by `axis_tvalid_i`.
- `capture_en_i`  in  1  when low, incoming beats are discarded and neither stored nor counted as dropped.
- `clear_i`  in  1  synchronous flush of FIFO, flags and counters.
- `rd_en_i`  in  1  pop request, one entry per cycle high.
- `rd_data_o`  out  DATA_WIDTH  popped sample; registered.
- `rd_valid_o`  out  1  one-cycle pulse qualifying `rd_data_o`.
- `count_o`  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
- `empty_o`  out  1  high when `count_o` == 0.
- `full_o`  out  1  high when `count_o` == 2^ADDR_WIDTH.
- `overflow_o`  out  1  sticky; set on the first dropped sample.
- `dropped_o`  out  16  count of dropped samples; saturates at 16'hFFFF.

## Operation
- **Push:** occurs when `axis_tvalid_i & capture_en_i & ~clear_i`, and the FIFO is not full or a pop happens in the same cycle. Data is written at `wr_ptr`, then `wr_ptr` increments.
- **Pop:** occurs when `rd_en_i & ~empty_o & ~clear_i`. `rd_data_o` is loaded from `rd_ptr`, then `rd_ptr` increments.
- **Pop on empty:** ignored. `rd_valid_o` stays 0, and there is no fall-through.
- **Drop:** occurs on a push attempt while full with no same-cycle pop.
  - `overflow_o` is set to 1.
  - `dropped_o` increments, saturating at 16'hFFFF.
  - The stored data is unchanged.
- **Simultaneous push and pop:**
  - When full: both happen and `count_o` is unchanged.
  - When empty: only the push happens; the pop is ignored.
- **Pointers:** ADDR_WIDTH wide and wrap modulo depth. `count_o` is a separate up/down counter, which updates as follows.
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- **`clear_i`:** has priority over push and pop in the same cycle.
  - Pointers, `count_o`, `overflow_o` and `dropped_o` go to 0.
  - `rd_valid_o` goes to 0.
  - `rd_data_o` holds its value.
  - Memory contents are not cleared.
- **`capture_en_i` deassertion:** takes effect on the same edge. A beat coincident with `capture_en_i` = 0 is discarded. Data already in the FIFO remains readable.
- **Storage:** inferred as simple dual-port RAM with one write port, one read port and a registered read. It is not reset.
- **Reset values:**
  - `rd_data_o` = 0, `rd_valid_o` = 0, `count_o` = 0.
  - `empty_o` = 1, `full_o` = 0.
  - `overflow_o` = 0, `dropped_o` = 0.
  - Both pointers = 0.
- **Reset mid-operation:** asynchronous assertion immediately forces all of the above. Any pending pop produces no `rd_valid_o`.

## Timing
- **Push latency:** beat sampled at edge N; `count_o`, `empty_o` and `full_o` reflect it after edge N.
- **Pop latency:** `rd_en_i` sampled at edge N; `rd_data_o` is valid and `rd_valid_o` = 1 for the cycle after edge N.
- **Earliest readback:** a push at edge N can be popped by `rd_en_i` sampled at edge N+1. Data then appears after edge N+1, so write-to-read latency is 2 cycles.
- **Flags:** `empty_o` and `full_o` are decoded from registered `count_o`; no extra latency.
- **Throughput:** one push and one pop per cycle, sustained.
- **Sticky flag:** `overflow_o` stays set until `clear_i` or reset.

## Test plan
- **Reset values:** apply reset, then release it -> `empty_o` = 1, `count_o` = 0, `rd_valid_o` = 0, `overflow_o` = 0.
- **Ordered round trip:**
  - Stimulus: with capture enabled, push 5 beats 32'h00000001..32'h00000005, then assert `rd_en_i` for 5 cycles.
  - Required: `rd_valid_o` pulses 5 times in order 1..5, each one cycle after its `rd_en_i`. `count_o` goes 5 -> 0 and `empty_o` = 1.
- **Overflow:**
  - Stimulus: push 260 beats with no reads.
  - Required: `full_o` = 1 after beat 256, `count_o` = 256, `overflow_o` = 1, `dropped_o` = 4.
  - Then pop 256: data equals beats 1..256.
- **Simultaneous push/pop:**
  - When full: push and pop on the same cycle -> `count_o` stays 256, `dropped_o` unchanged, and the popped data is the oldest entry.
  - When empty: push and pop on the same cycle -> `count_o` = 1 and no `rd_valid_o`.
- **Capture gating and empty pop:**
  - With `capture_en_i` = 0: 10 beats -> `count_o` = 0 and `dropped_o` = 0.
  - `rd_en_i` pulsed while empty -> `rd_valid_o` stays 0.
- **Clear and wrap:**
  - Stimulus: fill 300 beats, assert `clear_i` together with `rd_en_i` and `axis_tvalid_i`.
  - Required: `count_o` = 0, `overflow_o` = 0, `dropped_o` = 0, and no `rd_valid_o`.
  - Then stream 1000 beats with a one-cycle-behind reader: no drops, correct order across pointer wrap.
